// File: rtl/data_mem_responder.sv
// Data memory responder for the MIPS MEM stage: one outstanding load/store,
// fixed wait states, misaligned/out-of-range requests answered with an error.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; the initiator holds its request stable until that edge, and
    // the responder holds resp_* stable from resp_valid rising until accepted.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0]   w_idx;
    logic                w_err;
    logic                w_accept;
    logic                w_access;
    logic                w_mem_we;

    assign req_ready = rst_n && (r_state == S_IDLE);
    assign dbg_state = r_state;

    assign w_idx    = r_addr[ADDR_W+1:2];
    assign w_err    = (r_addr[1:0] != 2'b00) || ((r_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_accept = req_valid && req_ready;
    // Counter counts down to zero; the edge seen with zero is the access edge,
    // giving accept-to-response of LATENCY+1 edges (1 edge when LATENCY is 0).
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_mem_we = w_access && r_we && !w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_cnt   <= LAT_CNT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= w_err;
                        resp_rdata <= (r_we || w_err) ? 32'd0 : r_mem[w_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state    <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; writes are gated by the reset FSM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus a
// randomized mix checked against a word-array memory model.
module tb_data_mem_responder;

    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;
    localparam int BUDGET  = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [0:(1<<ADDR_W)-1];

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= (32'd4 << ADDR_W));
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] be);
        logic [31:0] w;
        if (model_err(addr)) return;
        w = model_mem[addr / 4];
        for (int i = 0; i < 4; i++)
            if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        model_mem[addr / 4] = w;
    endfunction

    function automatic logic [31:0] model_rdata(input logic we, input logic [31:0] addr);
        if (we || model_err(addr)) return 32'd0;
        return model_mem[addr / 4];
    endfunction

    // ---------------- drivers ----------------
    // Presents a request, waits for its accept and for resp_valid; leaves the
    // response pending. Called and returns at 1ns after a rising edge.
    task automatic issue_to_resp(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output int acc_wait, output int lat, output bit timeout);
        timeout  = 0;
        acc_wait = 0;
        lat      = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (req_ready !== 1'b1 && acc_wait < BUDGET) begin
            @(posedge clk); #1;
            acc_wait++;
        end
        if (acc_wait >= BUDGET) begin
            timeout = 1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        while (resp_valid !== 1'b1 && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= BUDGET) timeout = 1;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int bp,
                             output logic [31:0] rdata, output logic err, output int lat,
                             output int acc_wait, output bit stable, output bit timeout);
        stable = 1;
        rdata  = 32'hxxxxxxxx;
        err    = 1'bx;
        issue_to_resp(we, addr, wdata, be, acc_wait, lat, timeout);
        if (timeout) return;
        rdata = resp_rdata;
        err   = resp_err;
        repeat (bp) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err ||
                req_ready !== 1'b0)
                stable = 0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b valid=%b rdata=%h err=%b, want 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", req_ready, resp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_ready: ready=%b, want 0", req_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat, aw; bit st, to;
        drive_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, aw, st, to);
        model_store(32'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if (to || lat != LATENCY + 1 || rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL store_0x10: to=%0d lat=%0d rdata=%h err=%b, want 0 %0d 0 0",
                     to, lat, rd, er, LATENCY + 1);
        end
        drive_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, aw, st, to);
        checks++;
        if (to || lat != LATENCY + 1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL load_0x10: to=%0d lat=%0d rdata=%h err=%b, want 0 %0d deadbeef 0",
                     to, lat, rd, er, LATENCY + 1);
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd; logic er; int lat, aw; bit st, to;
        drive_req(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd, er, lat, aw, st, to);
        model_store(32'h10, 32'h11223344, 4'b0101);
        drive_req(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, aw, st, to);
        checks++;
        if (to || rd !== 32'hDE22BE44 || rd !== model_mem[4] || er !== 1'b0) begin
            errors++;
            $display("FAIL byte_enables: rdata=%h err=%b, want de22be44 0", rd, er);
        end
        drive_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, aw, st, to);
        checks++;
        if (to || rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_ack: to=%0d rdata=%h err=%b, want 0 0 0", to, rd, er);
        end
        drive_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, aw, st, to);
        checks++;
        if (rd !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL be_zero_unchanged: rdata=%h, want de22be44", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, aw; bit st, to;
        drive_req(1'b1, 32'h0, 32'hA5A50000, 4'hF, 0, rd, er, lat, aw, st, to);
        model_store(32'h0, 32'hA5A50000, 4'hF);
        drive_req(1'b0, 32'h13, 32'h0, 4'hF, 0, rd, er, lat, aw, st, to);
        checks++;
        if (to || rd !== 32'd0 || er !== 1'b1) begin
            errors++;
            $display("FAIL err_misaligned: rdata=%h err=%b, want 0 1", rd, er);
        end
        drive_req(1'b1, 32'h400, 32'h12345678, 4'hF, 0, rd, er, lat, aw, st, to);
        checks++;
        if (to || lat != LATENCY + 1 || rd !== 32'd0 || er !== 1'b1) begin
            errors++;
            $display("FAIL err_range_store: lat=%0d rdata=%h err=%b, want %0d 0 1",
                     lat, rd, er, LATENCY + 1);
        end
        drive_req(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, aw, st, to);
        checks++;
        if (rd !== model_mem[0] || er !== 1'b0) begin
            errors++;
            $display("FAIL err_word0_intact: rdata=%h err=%b, want %h 0", rd, er, model_mem[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, aw; bit st, to;
        drive_req(1'b1, 32'h30, 32'h0BADF00D, 4'hF, 0, rd, er, lat, aw, st, to);
        model_store(32'h30, 32'h0BADF00D, 4'hF);
        drive_req(1'b0, 32'h30, 32'h0, 4'h0, 5, rd, er, lat, aw, st, to);
        checks++;
        if (to || !st || rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL backpressure: stable=%0d rdata=%h, want 1 0badf00d", st, rd);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_handshake: ready=%b, want 1", req_ready);
        end
        drive_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, aw, st, to);
        checks++;
        if (to || aw != 0 || rd !== model_mem[4]) begin
            errors++;
            $display("FAIL back_to_back: accept_wait=%0d rdata=%h, want 0 %h", aw, rd, model_mem[4]);
        end
    endtask

    task automatic test_reset_during_wait();
        logic [31:0] rd; logic er; int lat, aw; bit st, to;
        bit seen;
        drive_req(1'b1, 32'h20, 32'h00000000, 4'hF, 0, rd, er, lat, aw, st, to);
        model_store(32'h20, 32'h00000000, 4'hF);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL wait_reset_no_resp: resp_valid seen=1, want 0");
        end
        drive_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, aw, st, to);
        checks++;
        if (to || rd !== 32'h00000000) begin
            errors++;
            $display("FAIL wait_reset_not_committed: rdata=%h, want 00000000", rd);
        end
    endtask

    task automatic test_reset_during_resp();
        logic [31:0] rd; logic er; int lat, aw; bit st, to;
        issue_to_resp(1'b1, 32'h24, 32'h5A5A1234, 4'hF, aw, lat, to);
        model_store(32'h24, 32'h5A5A1234, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL resp_reset_drop: valid=%b ready=%b, want 0 0", resp_valid, req_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue_to_resp(1'b0, 32'h24, 32'h0, 4'h0, aw, lat, to);
        checks++;
        if (to || resp_rdata !== 32'h5A5A1234) begin
            errors++;
            $display("FAIL resp_reset_committed: rdata=%h, want 5a5a1234", resp_rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL resp_reset_outputs: valid=%b rdata=%h err=%b, want 0 0 0",
                     resp_valid, resp_rdata, resp_err);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat, aw; bit st, to;
        logic [31:0] addr, wd, exp_rd;
        logic [3:0]  be;
        logic        we, exp_er;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            drive_req(1'b1, 32'(i * 4), wd, 4'hF, 0, rd, er, lat, aw, st, to);
            model_store(32'(i * 4), wd, 4'hF);
        end
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       addr = 32'($urandom_range(0, 63));
                1:       addr = 32'h400 + 32'($urandom_range(0, 15) * 4);
                default: addr = 32'($urandom_range(0, 15) * 4);
            endcase
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            exp_er = model_err(addr);
            exp_rd = model_rdata(we, addr);
            drive_req(we, addr, wd, be, $urandom_range(0, 3), rd, er, lat, aw, st, to);
            if (we) model_store(addr, wd, be);
            checks++;
            if (to || !st || lat != LATENCY + 1 || rd !== exp_rd || er !== exp_er) begin
                errors++;
                $display("FAIL random_%0d: we=%b addr=%h lat=%0d stable=%0d rdata=%h err=%b, want lat %0d rdata %h err %b",
                         n, we, addr, lat, st, rd, er, LATENCY + 1, exp_rd, exp_er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enables();
        test_errors();
        test_back_to_back();
        test_reset_during_wait();
        test_reset_during_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
